text_frame_rx: RTL and testbench

- Receive-side deframer for the text link. It takes the hard-decision serial bitstream after demodulation and hunts for a sync byte.
- It parses a length-prefixed frame of text bytes, checks an XOR checksum, and hands payload bytes to the decrypt/decompress/sink path over a valid/ready interface.
- It is the counterpart of the transmit framer that serialises source text onto the channel.

---
 rtl/text_link_pkg.sv | 16 +
 rtl/rx_byte_fifo.sv | 55 +++++
 rtl/text_frame_rx.sv | 156 +++++++++++++++
 tb/tb_text_frame_rx.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_link_pkg.sv
// Shared constants and state encoding for the text link framer/deframer.
// Used by both the receive deframer and the transmit framer.
package text_link_pkg;

    localparam logic [7:0] SYNC_WORD = 8'h7E;
    localparam int         MAX_LEN   = 32;
    localparam int         CHK_W     = 8;

    typedef enum logic [1:0] {
        HUNT,
        LEN,
        PAYLOAD,
        CHECK
    } link_state_t;

endpackage

// File: rtl/rx_byte_fifo.sv
// Small synchronous FIFO with a combinational head; a push while full is
// accepted only if a pop happens in the same cycle.
module rx_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + (AW+1)'(1);
            else if (do_pop && !do_push)
                count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/text_frame_rx.sv
// Serial deframer: hunts for sync, parses a length-prefixed payload,
// checks an XOR checksum and streams payload bytes out cut-through.
module text_frame_rx #(
    parameter logic [7:0] SYNC_WORD  = text_link_pkg::SYNC_WORD,
    parameter int         MAX_LEN    = text_link_pkg::MAX_LEN,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] data_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_done,
    output logic       frame_err,
    output logic       overflow,
    output logic       busy
);

    import text_link_pkg::*;

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    link_state_t      state, state_n;
    logic [7:0]       shift, shift_n;
    logic [3:0]       bit_cnt, bit_cnt_n;
    logic [7:0]       byte_cnt, byte_cnt_n;
    logic [7:0]       len, len_n;
    logic [CHK_W-1:0] chk, chk_n;
    logic             drop, drop_n;
    logic             done_n, err_n, ovf_n;

    logic [7:0] byte_in;
    logic [3:0] field_cnt;
    logic       byte_done;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;

    assign byte_in   = {shift[6:0], bit_in};
    assign byte_done = bit_valid && (bit_cnt == 4'd7);
    assign field_cnt = (bit_cnt == 4'd7) ? 4'd0 : bit_cnt + 4'd1;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign busy      = (state != HUNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HUNT;
            shift      <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            len        <= '0;
            chk        <= '0;
            drop       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            shift      <= shift_n;
            bit_cnt    <= bit_cnt_n;
            byte_cnt   <= byte_cnt_n;
            len        <= len_n;
            chk        <= chk_n;
            drop       <= drop_n;
            frame_done <= done_n;
            frame_err  <= err_n;
            overflow   <= ovf_n;
        end
    end

    always_comb begin
        state_n    = state;
        shift_n    = shift;
        bit_cnt_n  = bit_cnt;
        byte_cnt_n = byte_cnt;
        len_n      = len;
        chk_n      = chk;
        drop_n     = drop;
        push       = 1'b0;
        done_n     = 1'b0;
        err_n      = 1'b0;
        ovf_n      = 1'b0;
        if (bit_valid) begin
            shift_n = byte_in;
            unique case (state)
                HUNT: begin
                    // bit_cnt is a fill counter here, saturating at 8
                    if (bit_cnt >= 4'd7 && byte_in == SYNC_WORD) begin
                        state_n   = LEN;
                        bit_cnt_n = '0;
                    end else if (bit_cnt != 4'd8) begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end
                LEN: begin
                    bit_cnt_n = field_cnt;
                    if (byte_done) begin
                        len_n = byte_in;
                        chk_n = byte_in;
                        if (byte_in == 8'd0 || byte_in > MAX_LEN_B) begin
                            err_n     = 1'b1;
                            state_n   = HUNT;
                            bit_cnt_n = '0;
                        end else begin
                            state_n    = PAYLOAD;
                            byte_cnt_n = '0;
                            drop_n     = 1'b0;
                        end
                    end
                end
                PAYLOAD: begin
                    bit_cnt_n = field_cnt;
                    if (byte_done) begin
                        chk_n = chk ^ byte_in;
                        push  = 1'b1;
                        if (full && !pop) begin
                            ovf_n  = 1'b1;
                            drop_n = 1'b1;
                        end
                        byte_cnt_n = byte_cnt + 8'd1;
                        if (byte_cnt_n == len)
                            state_n = CHECK;
                    end
                end
                CHECK: begin
                    bit_cnt_n = field_cnt;
                    if (byte_done) begin
                        done_n    = 1'b1;
                        err_n     = (byte_in != chk) || drop;
                        state_n   = HUNT;
                        bit_cnt_n = '0;
                    end
                end
            endcase
        end
    end

    rx_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (byte_in),
        .full  (full),
        .pop   (pop),
        .dout  (data_out),
        .empty (empty)
    );

endmodule

// File: tb/tb_text_frame_rx.sv
// Directed bench for text_frame_rx: good/bad frames, backpressure,
// gapped misaligned input and reset mid-frame.
module tb_text_frame_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       bit_in;
    logic       bit_valid;
    logic [7:0] data_out;
    logic       out_valid;
    logic       out_ready;
    logic       frame_done;
    logic       frame_err;
    logic       overflow;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int done_cnt, err_cnt, ovf_cnt, both_cnt;
    logic [7:0] got[$];

    always #5 clk = ~clk;

    text_frame_rx dut (
        .clk        (clk),
        .reset      (reset),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .busy       (busy)
    );

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) got.push_back(data_out);
            if (frame_done) done_cnt++;
            if (frame_err) err_cnt++;
            if (overflow) ovf_cnt++;
            if (frame_done && frame_err) both_cnt++;
        end
    end

    task automatic clear_mon();
        done_cnt = 0; err_cnt = 0; ovf_cnt = 0; both_cnt = 0;
        got.delete();
    endtask

    task automatic idle(input int n);
        bit_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        bit_in = b;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        if (gap > 0) idle(gap);
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap);
        for (int i = 7; i >= 0; i--) send_bit(v[i], gap);
    endtask

    task automatic test_reset();
        reset = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({out_valid, frame_done, frame_err, overflow, busy} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000",
                     {out_valid, frame_done, frame_err, overflow, busy});
        end
        total++;
        if (data_out !== 8'h00) begin
            bad++; $display("FAIL reset_data: got %h want 00", data_out);
        end
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_good_frame();
        logic [7:0] exp [3] = '{8'h48, 8'h69, 8'h21};
        clear_mon();
        send_byte(8'h7E, 0);
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL good_busy_after_sync: got %b want 1", busy);
        end
        send_byte(8'h03, 0);
        for (int i = 0; i < 3; i++) send_byte(exp[i], 0);
        send_byte(8'h03, 0);
        idle(4);
        total++;
        if (got.size() !== 3) begin
            bad++; $display("FAIL good_count: got %0d want 3", got.size());
        end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            total++;
            if (got[i] !== exp[i]) begin
                bad++; $display("FAIL good_byte%0d: got %h want %h", i, got[i], exp[i]);
            end
        end
        total++;
        if ({done_cnt, err_cnt, ovf_cnt} !== {32'd1, 32'd0, 32'd0}) begin
            bad++;
            $display("FAIL good_pulses: got done=%0d err=%0d ovf=%0d want 1 0 0",
                     done_cnt, err_cnt, ovf_cnt);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL good_busy_end: got %b want 0", busy);
        end
    endtask

    task automatic test_bad_checksum();
        logic [7:0] exp [3] = '{8'h48, 8'h69, 8'h21};
        clear_mon();
        send_byte(8'h7E, 0);
        send_byte(8'h03, 0);
        for (int i = 0; i < 3; i++) send_byte(exp[i], 0);
        send_byte(8'h04, 0);
        idle(4);
        total++;
        if (got.size() !== 3) begin
            bad++; $display("FAIL badchk_count: got %0d want 3", got.size());
        end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            total++;
            if (got[i] !== exp[i]) begin
                bad++; $display("FAIL badchk_byte%0d: got %h want %h", i, got[i], exp[i]);
            end
        end
        total++;
        if ({done_cnt, err_cnt, both_cnt} !== {32'd1, 32'd1, 32'd1}) begin
            bad++;
            $display("FAIL badchk_pulses: got done=%0d err=%0d both=%0d want 1 1 1",
                     done_cnt, err_cnt, both_cnt);
        end
    endtask

    task automatic test_bad_length();
        logic [7:0] lens [2] = '{8'h00, 8'h21};
        for (int k = 0; k < 2; k++) begin
            clear_mon();
            send_byte(8'h7E, 0);
            send_byte(lens[k], 0);
            total++;
            if ({frame_err, frame_done, busy} !== 3'b100) begin
                bad++;
                $display("FAIL badlen%0d_now: got err,done,busy=%b want 100",
                         k, {frame_err, frame_done, busy});
            end
            idle(3);
            total++;
            if ({err_cnt, done_cnt, got.size(), 32'(out_valid)} !==
                {32'd1, 32'd0, 32'd0, 32'd0}) begin
                bad++;
                $display("FAIL badlen%0d_after: got err=%0d done=%0d pops=%0d ov=%b want 1 0 0 0",
                         k, err_cnt, done_cnt, got.size(), out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] pay [5] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        clear_mon();
        out_ready = 1'b0;
        send_byte(8'h7E, 0);
        send_byte(8'h05, 0);
        for (int i = 0; i < 5; i++) send_byte(pay[i], 0);
        // correct XOR of 05 41 42 43 44 45; the error must come from the drop
        send_byte(8'h44, 0);
        idle(2);
        total++;
        if ({ovf_cnt, done_cnt, err_cnt, both_cnt} !==
            {32'd1, 32'd1, 32'd1, 32'd1}) begin
            bad++;
            $display("FAIL bp_pulses: got ovf=%0d done=%0d err=%0d both=%0d want 1 1 1 1",
                     ovf_cnt, done_cnt, err_cnt, both_cnt);
        end
        total++;
        if ({out_valid, data_out} !== {1'b1, 8'h41} || got.size() !== 0) begin
            bad++;
            $display("FAIL bp_hold: got ov=%b data=%h pops=%0d want 1 41 0",
                     out_valid, data_out, got.size());
        end
        out_ready = 1'b1;
        idle(8);
        total++;
        if (got.size() !== 4) begin
            bad++; $display("FAIL bp_drain_count: got %0d want 4", got.size());
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            total++;
            if (got[i] !== pay[i]) begin
                bad++; $display("FAIL bp_byte%0d: got %h want %h", i, got[i], pay[i]);
            end
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_empty: got %b want 0", out_valid);
        end
    endtask

    task automatic test_gaps_misaligned();
        logic [7:0] exp [3] = '{8'h48, 8'h69, 8'h21};
        clear_mon();
        send_bit(1'b1, 1);
        send_bit(1'b0, 1);
        send_bit(1'b1, 1);
        send_byte(8'h7E, 1);
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL gap_sync: got busy=%b want 1", busy);
        end
        send_byte(8'h03, 1);
        for (int i = 0; i < 3; i++) send_byte(exp[i], 1);
        send_byte(8'h03, 1);
        idle(4);
        total++;
        if (got.size() !== 3) begin
            bad++; $display("FAIL gap_count: got %0d want 3", got.size());
        end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            total++;
            if (got[i] !== exp[i]) begin
                bad++; $display("FAIL gap_byte%0d: got %h want %h", i, got[i], exp[i]);
            end
        end
        total++;
        if ({done_cnt, err_cnt} !== {32'd1, 32'd0}) begin
            bad++;
            $display("FAIL gap_pulses: got done=%0d err=%0d want 1 0", done_cnt, err_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] exp [3] = '{8'h48, 8'h69, 8'h21};
        clear_mon();
        send_byte(8'h7E, 0);
        send_byte(8'h03, 0);
        send_byte(8'h48, 0);
        send_byte(8'h69, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        total++;
        if ({out_valid, busy, frame_done, frame_err} !== 4'b0000) begin
            bad++;
            $display("FAIL rst_mid_now: got ov,busy,done,err=%b want 0000",
                     {out_valid, busy, frame_done, frame_err});
        end
        idle(3);
        total++;
        if ({done_cnt, err_cnt, ovf_cnt} !== {32'd0, 32'd0, 32'd0}) begin
            bad++;
            $display("FAIL rst_mid_pulses: got done=%0d err=%0d ovf=%0d want 0 0 0",
                     done_cnt, err_cnt, ovf_cnt);
        end
        clear_mon();
        send_byte(8'h7E, 0);
        send_byte(8'h03, 0);
        for (int i = 0; i < 3; i++) send_byte(exp[i], 0);
        send_byte(8'h03, 0);
        idle(4);
        total++;
        if (got.size() !== 3) begin
            bad++; $display("FAIL rst_next_count: got %0d want 3", got.size());
        end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            total++;
            if (got[i] !== exp[i]) begin
                bad++; $display("FAIL rst_next_byte%0d: got %h want %h", i, got[i], exp[i]);
            end
        end
        total++;
        if ({done_cnt, err_cnt} !== {32'd1, 32'd0}) begin
            bad++;
            $display("FAIL rst_next_pulses: got done=%0d err=%0d want 1 0",
                     done_cnt, err_cnt);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_bad_length();
        test_backpressure();
        test_gaps_misaligned();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
